// File: rtl/rf_writeback.sv
// Register file fronted by a small writeback queue. Two writebacks can be
// accepted per cycle, but the queue drains into the register file one entry per cycle.
module rf_writeback #(
    parameter int DEPTH   = 4,
    parameter int NUMREGS = 32
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     wbEnableA_i,
    input  logic                     wbEnableB_i,
    input  logic [4:0]               wbAddressA_i,
    input  logic [4:0]               wbAddressB_i,
    input  logic [15:0]              wbDataA_i,
    input  logic [15:0]              wbDataB_i,
    input  logic [4:0]               rdAddressA_i,
    input  logic [4:0]               rdAddressB_i,
    output logic [15:0]              rdDataA_o,
    output logic [15:0]              rdDataB_o,
    output logic                     rdPendingA_o,
    output logic                     rdPendingB_o,
    output logic                     stall_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] data;
    } QueueEntry;

    QueueEntry       queue [DEPTH];
    logic [15:0]     regFile [NUMREGS];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   tailB;
    logic [CW-1:0]   space;
    logic            pop;
    logic            acceptA;
    logic            acceptB;
    logic            dropped;
    QueueEntry       headEntry;

    // Space counts the slot freed by this edge's pop. When space runs out,
    // port B is dropped before port A so that the older write survives.
    always_comb begin
        pop       = (count_o != '0);
        space     = CW'(DEPTH) - count_o + CW'(pop);
        acceptA   = wbEnableA_i && (space != '0);
        acceptB   = wbEnableB_i && (wbEnableA_i ? (space >= CW'(2)) : (space != '0));
        dropped   = (wbEnableA_i && !acceptA) || (wbEnableB_i && !acceptB);
        tailB     = acceptA ? tail + PW'(1) : tail;
        headEntry = queue[head];
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            head       <= '0;
            tail       <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
            rdDataA_o  <= '0;
            rdDataB_o  <= '0;
            for (int i = 0; i < NUMREGS; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            if (acceptA) queue[tail]  <= '{addr: wbAddressA_i, data: wbDataA_i};
            if (acceptB) queue[tailB] <= '{addr: wbAddressB_i, data: wbDataB_i};
            tail <= tail + PW'(acceptA) + PW'(acceptB);
            if (pop) begin
                regFile[headEntry.addr] <= headEntry.data;
                head <= head + PW'(1);
            end
            count_o <= count_o + CW'(acceptA) + CW'(acceptB) - CW'(pop);
            if (dropped) overflow_o <= 1'b1;
            // Forward the entry committing at this edge so readers see it immediately
            rdDataA_o <= (pop && headEntry.addr == rdAddressA_i) ? headEntry.data : regFile[rdAddressA_i];
            rdDataB_o <= (pop && headEntry.addr == rdAddressB_i) ? headEntry.data : regFile[rdAddressB_i];
        end
    end

    // Only the occupied slots, counted from the head, are searched.
    always_comb begin
        logic [PW-1:0] slot;
        slot         = head;
        rdPendingA_o = 1'b0;
        rdPendingB_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PW'(i);
            if (CW'(i) < count_o) begin
                if (queue[slot].addr == rdAddressA_i) rdPendingA_o = 1'b1;
                if (queue[slot].addr == rdAddressB_i) rdPendingB_o = 1'b1;
            end
        end
    end

    assign stall_o = (count_o >= CW'(DEPTH - 2));

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: reset, single/dual writes, fill/overflow,
// read bypass, reset mid-drain and pointer wrap-around.
module tb_rf_writeback;

    logic        clock_i;
    logic        reset_i;
    logic        wbEnableA_i, wbEnableB_i;
    logic [4:0]  wbAddressA_i, wbAddressB_i;
    logic [15:0] wbDataA_i, wbDataB_i;
    logic [4:0]  rdAddressA_i, rdAddressB_i;
    logic [15:0] rdDataA_o, rdDataB_o;
    logic        rdPendingA_o, rdPendingB_o;
    logic        stall_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    int vectors    = 0;
    int miscompares = 0;

    rf_writeback #(.DEPTH(4), .NUMREGS(32)) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .wbEnableA_i  (wbEnableA_i),
        .wbEnableB_i  (wbEnableB_i),
        .wbAddressA_i (wbAddressA_i),
        .wbAddressB_i (wbAddressB_i),
        .wbDataA_i    (wbDataA_i),
        .wbDataB_i    (wbDataB_i),
        .rdAddressA_i (rdAddressA_i),
        .rdAddressB_i (rdAddressB_i),
        .rdDataA_o    (rdDataA_o),
        .rdDataB_o    (rdDataB_o),
        .rdPendingA_o (rdPendingA_o),
        .rdPendingB_o (rdPendingB_o),
        .stall_o      (stall_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic applyStimulus();
        @(posedge clock_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idleWrites();
        wbEnableA_i = 1'b0;
        wbEnableB_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b0;
        idleWrites();
        wbAddressA_i = '0; wbAddressB_i = '0;
        wbDataA_i = '0; wbDataB_i = '0;
        rdAddressA_i = '0; rdAddressB_i = '0;
        applyStimulus();
        applyStimulus();
        reset_i = 1'b1;

        // Reset state
        checkOutput("rst_count", count_o, 0);
        checkOutput("rst_stall", stall_o, 0);
        checkOutput("rst_overflow", overflow_o, 0);
        checkOutput("rst_rdDataA", rdDataA_o, 0);
        checkOutput("rst_pendingA", rdPendingA_o, 0);

        // Single write r5 = 0x1234
        wbEnableA_i = 1'b1; wbAddressA_i = 5'd5; wbDataA_i = 16'h1234;
        rdAddressA_i = 5'd5;
        applyStimulus();
        idleWrites();
        checkOutput("single_count", count_o, 1);
        checkOutput("single_pending", rdPendingA_o, 1);
        checkOutput("single_rd_old", rdDataA_o, 16'h0000);
        applyStimulus();
        checkOutput("single_rd", rdDataA_o, 16'h1234);
        checkOutput("single_pending_clr", rdPendingA_o, 0);
        checkOutput("single_count_clr", count_o, 0);

        // Dual same-address writes: B wins
        wbEnableA_i = 1'b1; wbAddressA_i = 5'd3; wbDataA_i = 16'h00AA;
        wbEnableB_i = 1'b1; wbAddressB_i = 5'd3; wbDataB_i = 16'h00BB;
        rdAddressA_i = 5'd3;
        applyStimulus();
        idleWrites();
        checkOutput("dual_count", count_o, 2);
        checkOutput("dual_stall", stall_o, 1);
        applyStimulus();
        checkOutput("dual_first_commit", rdDataA_o, 16'h00AA);
        applyStimulus();
        checkOutput("dual_second_commit", rdDataA_o, 16'h00BB);
        applyStimulus();
        checkOutput("dual_final", rdDataA_o, 16'h00BB);
        checkOutput("dual_drained", count_o, 0);

        // Fill: dual writes every cycle while one entry drains per cycle
        rdAddressA_i = 5'd16; rdAddressB_i = 5'd17;
        wbEnableA_i = 1'b1; wbEnableB_i = 1'b1;
        wbAddressA_i = 5'd10; wbDataA_i = 16'h1010;
        wbAddressB_i = 5'd11; wbDataB_i = 16'h1111;
        applyStimulus();
        checkOutput("fill1_count", count_o, 2);
        checkOutput("fill1_stall", stall_o, 1);
        wbAddressA_i = 5'd12; wbDataA_i = 16'h1212;
        wbAddressB_i = 5'd13; wbDataB_i = 16'h1313;
        applyStimulus();
        checkOutput("fill2_count", count_o, 3);
        wbAddressA_i = 5'd14; wbDataA_i = 16'h1414;
        wbAddressB_i = 5'd15; wbDataB_i = 16'h1515;
        applyStimulus();
        checkOutput("fill3_count", count_o, 4);
        checkOutput("fill3_overflow", overflow_o, 0);
        wbAddressA_i = 5'd16; wbDataA_i = 16'h1616;
        wbAddressB_i = 5'd17; wbDataB_i = 16'h1717;
        applyStimulus();
        idleWrites();
        checkOutput("fill4_count", count_o, 4);
        checkOutput("fill4_overflow", overflow_o, 1);
        checkOutput("fill4_pendingA", rdPendingA_o, 1);
        checkOutput("fill4_pendingB_dropped", rdPendingB_o, 0);
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("fill_drained", count_o, 0);
        checkOutput("fill_stall_low", stall_o, 0);
        checkOutput("fill_overflow_sticky", overflow_o, 1);
        checkOutput("fill_r16", rdDataA_o, 16'h1616);
        checkOutput("fill_r17_dropped", rdDataB_o, 16'h0000);

        // Bypass: read r7 exactly when the newer value commits
        rdAddressA_i = 5'd7; rdAddressB_i = 5'd7;
        wbEnableA_i = 1'b1; wbAddressA_i = 5'd7; wbDataA_i = 16'h1111;
        applyStimulus();
        idleWrites();
        applyStimulus();
        wbEnableA_i = 1'b1; wbAddressA_i = 5'd7; wbDataA_i = 16'hBEEF;
        applyStimulus();
        idleWrites();
        checkOutput("bypass_old", rdDataA_o, 16'h1111);
        applyStimulus();
        checkOutput("bypass_A", rdDataA_o, 16'hBEEF);
        checkOutput("bypass_B", rdDataB_o, 16'hBEEF);

        // Reset with three entries queued; writes presented during reset are ignored
        wbEnableA_i = 1'b1; wbEnableB_i = 1'b1;
        wbAddressA_i = 5'd20; wbDataA_i = 16'h2020;
        wbAddressB_i = 5'd21; wbDataB_i = 16'h2121;
        applyStimulus();
        wbAddressA_i = 5'd22; wbDataA_i = 16'h2222;
        wbAddressB_i = 5'd23; wbDataB_i = 16'h2323;
        applyStimulus();
        checkOutput("prereset_count", count_o, 3);
        rdAddressA_i = 5'd20; rdAddressB_i = 5'd21;
        reset_i = 1'b0;
        applyStimulus();
        reset_i = 1'b1;
        idleWrites();
        checkOutput("midrst_count", count_o, 0);
        checkOutput("midrst_overflow", overflow_o, 0);
        checkOutput("midrst_stall", stall_o, 0);
        checkOutput("midrst_pendingB", rdPendingB_o, 0);
        checkOutput("midrst_rdDataA", rdDataA_o, 0);
        applyStimulus();
        checkOutput("midrst_r20", rdDataA_o, 0);
        checkOutput("midrst_r21", rdDataB_o, 0);
        checkOutput("midrst_count_hold", count_o, 0);

        // Wrap-around: ten single writes r0..r9; disabled port B must be ignored
        wbAddressB_i = 5'd9; wbDataB_i = 16'hDEAD;
        for (int i = 0; i < 10; i++) begin
            wbEnableA_i = 1'b1;
            wbAddressA_i = 5'(i);
            wbDataA_i = 16'h0100 + 16'(i);
            applyStimulus();
            checkOutput($sformatf("wrap_count_%0d", i), count_o, 1);
        end
        idleWrites();
        applyStimulus();
        applyStimulus();
        checkOutput("wrap_drained", count_o, 0);
        checkOutput("wrap_overflow", overflow_o, 0);
        for (int i = 0; i < 10; i++) begin
            rdAddressA_i = 5'(i);
            applyStimulus();
            checkOutput($sformatf("wrap_read_r%0d", i), rdDataA_o, 16'h0100 + 16'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
